// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage, plus its pipeline controls.
// The decode stage uses the master view; the fetch/execute environment uses the slave view.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [2:0]        rd;
    logic [2:0]        rs1;
    logic [2:0]        rs2;
    logic [XLEN-1:0]   imm;
    logic              imm_mode;
    logic              alu_mode;
    logic [2:0]        alu_func;
    logic              set_flags;
    logic              to_pc;
    logic              ldst;
    logic              store;
    logic              write_en;
    logic              is_halt;
    logic              is_nop;
    logic              branch;
    logic [3:0]        br_cond;

    logic              flush;
    logic              resume;
    logic              halted;

    modport master (
        input  in_valid, in_instr, in_pc, out_ready, flush, resume,
        output in_ready, out_valid, out_pc, rd, rs1, rs2, imm, imm_mode, alu_mode,
               alu_func, set_flags, to_pc, ldst, store, write_en, is_halt, is_nop,
               branch, br_cond, halted
    );

    modport slave (
        output in_valid, in_instr, in_pc, out_ready, flush, resume,
        input  in_ready, out_valid, out_pc, rd, rs1, rs2, imm, imm_mode, alu_mode,
               alu_func, set_flags, to_pc, ldst, store, write_en, is_halt, is_nop,
               branch, br_cond, halted
    );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode stage with valid/ready handshake, 2-entry skid buffer,
// pipeline flush and a sticky halted state.
//
//   state  | meaning
//   RUN    | normal operation, instructions accepted when skid is empty
//   HALTED | a halt instruction was accepted; intake stopped until resume
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int PC_W     = 16,
    parameter bit IMM_SEXT = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.master bus
);
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } stateT;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [2:0]      rd;
        logic [2:0]      rs1;
        logic [2:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            immMode;
        logic            aluMode;
        logic [2:0]      aluFunc;
        logic            setFlags;
        logic            toPc;
        logic            ldst;
        logic            store;
        logic            writeEn;
        logic            isHalt;
        logic            isNop;
        logic            branch;
        logic [3:0]      brCond;
    } bundleT;

    function automatic bundleT decodeInstr(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        bundleT b;
        logic signed [15:0] immS;
        immS       = instr[15:0];
        b.pc       = pc;
        b.rd       = instr[24:22];
        b.rs1      = instr[21:19];
        b.rs2      = instr[18:16];
        if (IMM_SEXT)
            b.imm = XLEN'(immS);
        else
            b.imm = XLEN'(instr[15:0]);
        b.immMode  = (instr[31:30] == 2'b00) || (instr[28:26] == 3'b000);
        b.aluMode  = ~instr[29];
        b.aluFunc  = instr[31] ? 3'b001 : instr[27:25];
        b.setFlags = instr[28] & (instr[31:29] == 3'b001);
        b.toPc     = (instr[31:30] == 2'b11) && (instr[28:26] == 3'b000);
        b.ldst     = (instr[31:30] == 2'b10);
        b.store    = instr[25];
        b.writeEn  = ~instr[31] | ((instr[31:30] == 2'b10) & instr[25]);
        b.isHalt   = (instr[31:30] == 2'b11) & instr[28];
        b.isNop    = (instr[31:30] == 2'b11) && (instr[28:27] == 2'b01);
        b.branch   = (instr[31:30] == 2'b11) && (instr[28:27] == 2'b00);
        b.brCond   = instr[26] ? instr[24:21] : 4'hE;
        return b;
    endfunction

    stateT  state;
    logic   mainValid;
    logic   skidValid;
    bundleT mainEntry;
    bundleT skidEntry;
    bundleT incoming;
    logic   inReady;
    logic   accept;
    logic   issue;

    assign incoming = decodeInstr(bus.in_instr, bus.in_pc);

    // Intake depends only on registered state and flush, never on out_ready.
    assign inReady = ~skidValid & (state == RUN) & ~bus.flush;
    assign accept  = bus.in_valid & inReady;
    assign issue   = mainValid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            mainEntry <= '0;
            skidEntry <= '0;
        end else begin
            if (bus.flush) begin
                mainValid <= 1'b0;
                skidValid <= 1'b0;
            end else if (issue || !mainValid) begin
                if (skidValid) begin
                    mainEntry <= skidEntry;
                    mainValid <= 1'b1;
                    skidValid <= 1'b0;
                end else if (accept) begin
                    mainEntry <= incoming;
                    mainValid <= 1'b1;
                end else begin
                    mainValid <= 1'b0;
                end
            end else if (accept) begin
                skidEntry <= incoming;
                skidValid <= 1'b1;
            end

            case (state)
                RUN:     if (accept && incoming.isHalt) state <= HALTED;
                HALTED:  if (bus.resume) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.halted    = (state == HALTED);
    assign bus.out_valid = mainValid;
    assign bus.out_pc    = mainEntry.pc;
    assign bus.rd        = mainEntry.rd;
    assign bus.rs1       = mainEntry.rs1;
    assign bus.rs2       = mainEntry.rs2;
    assign bus.imm       = mainEntry.imm;
    assign bus.imm_mode  = mainEntry.immMode;
    assign bus.alu_mode  = mainEntry.aluMode;
    assign bus.alu_func  = mainEntry.aluFunc;
    assign bus.set_flags = mainEntry.setFlags;
    assign bus.to_pc     = mainEntry.toPc;
    assign bus.ldst      = mainEntry.ldst;
    assign bus.store     = mainEntry.store;
    assign bus.write_en  = mainEntry.writeEn;
    assign bus.is_halt   = mainEntry.isHalt;
    assign bus.is_nop    = mainEntry.isNop;
    assign bus.branch    = mainEntry.branch;
    assign bus.br_cond   = mainEntry.brCond;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default instance plus a 64-bit zero-extending variant.
module tb_decode_stage;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    decode_stage_if #(.XLEN(32), .PC_W(16)) dbus ();
    decode_stage_if #(.XLEN(64), .PC_W(16)) dbus64 ();

    decode_stage #(.XLEN(32), .PC_W(16), .IMM_SEXT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dbus)
    );

    decode_stage #(.XLEN(64), .PC_W(16), .IMM_SEXT(1'b0)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dbus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [15:0] pc);
        dbus.in_valid = v;
        dbus.in_instr = instr;
        dbus.in_pc    = pc;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        drive(1'b0, 32'h0, 16'h0);
        dbus.out_ready   = 1'b0;
        dbus.flush       = 1'b0;
        dbus.resume      = 1'b0;
        dbus64.in_valid  = 1'b0;
        dbus64.in_instr  = 32'h0;
        dbus64.in_pc     = 16'h0;
        dbus64.out_ready = 1'b0;
        dbus64.flush     = 1'b0;
        dbus64.resume    = 1'b0;

        // Reset state
        #13;
        check("rst_out_valid", 64'(dbus.out_valid), 64'd0);
        check("rst_halted",    64'(dbus.halted),    64'd0);
        check("rst_in_ready",  64'(dbus.in_ready),  64'd1);
        check("rst_rd",        64'(dbus.rd),        64'd0);
        check("rst_imm",       64'(dbus.imm),       64'd0);
        check("rst_out_pc",    64'(dbus.out_pc),    64'd0);
        rst_n = 1'b1;

        // Streaming, plus the 64-bit zero-extend variant
        dbus.out_ready   = 1'b1;
        drive(1'b1, 32'h0A4B_1234, 16'h0010);
        dbus64.in_valid  = 1'b1;
        dbus64.in_instr  = 32'h0000_8001;
        dbus64.in_pc     = 16'h0002;
        tick();
        check("s1_valid",     64'(dbus.out_valid), 64'd1);
        check("s1_pc",        64'(dbus.out_pc),    64'h10);
        check("s1_rd",        64'(dbus.rd),        64'd1);
        check("s1_rs1",       64'(dbus.rs1),       64'd1);
        check("s1_rs2",       64'(dbus.rs2),       64'd3);
        check("s1_imm",       64'(dbus.imm),       64'h1234);
        check("s1_alu_func",  64'(dbus.alu_func),  64'd5);
        check("s1_write_en",  64'(dbus.write_en),  64'd1);
        check("s1_imm_mode",  64'(dbus.imm_mode),  64'd1);
        check("s1_store",     64'(dbus.store),     64'd1);
        check("s1_br_cond",   64'(dbus.br_cond),   64'hE);
        check("v64_valid",    64'(dbus64.out_valid), 64'd1);
        check("v64_imm",      dbus64.imm,            64'h0000_0000_0000_8001);
        dbus64.in_valid = 1'b0;
        drive(1'b1, 32'h4000_8001, 16'h0014);
        tick();
        check("s2_valid",     64'(dbus.out_valid), 64'd1);
        check("s2_pc",        64'(dbus.out_pc),    64'h14);
        check("s2_imm",       64'(dbus.imm),       64'hFFFF_8001);
        drive(1'b0, 32'h0, 16'h0);
        tick();
        check("s3_idle",      64'(dbus.out_valid), 64'd0);

        // Backpressure: A in main, B in skid, C refused, then in-order drain
        dbus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_1111, 16'h0020);
        tick();
        check("bp_a_valid",   64'(dbus.out_valid), 64'd1);
        check("bp_a_pc",      64'(dbus.out_pc),    64'h20);
        check("bp_rdy1",      64'(dbus.in_ready),  64'd1);
        drive(1'b1, 32'h0000_2222, 16'h0024);
        tick();
        check("bp_hold_pc",   64'(dbus.out_pc),    64'h20);
        check("bp_rdy2",      64'(dbus.in_ready),  64'd0);
        drive(1'b1, 32'h0000_3333, 16'h0028);
        tick();
        check("bp_hold_pc2",  64'(dbus.out_pc),    64'h20);
        check("bp_hold_imm",  64'(dbus.imm),       64'h1111);
        check("bp_rdy3",      64'(dbus.in_ready),  64'd0);
        dbus.out_ready = 1'b1;
        tick();
        check("bp_b_valid",   64'(dbus.out_valid), 64'd1);
        check("bp_b_pc",      64'(dbus.out_pc),    64'h24);
        check("bp_rdy4",      64'(dbus.in_ready),  64'd1);
        tick();
        check("bp_c_valid",   64'(dbus.out_valid), 64'd1);
        check("bp_c_pc",      64'(dbus.out_pc),    64'h28);
        check("bp_c_imm",     64'(dbus.imm),       64'h3333);
        drive(1'b0, 32'h0, 16'h0);
        tick();
        check("bp_drained",   64'(dbus.out_valid), 64'd0);

        // Halt and resume
        drive(1'b1, 32'hD000_0000, 16'h0030);
        tick();
        check("h_valid",      64'(dbus.out_valid), 64'd1);
        check("h_is_halt",    64'(dbus.is_halt),   64'd1);
        check("h_halted",     64'(dbus.halted),    64'd1);
        check("h_in_ready",   64'(dbus.in_ready),  64'd0);
        drive(1'b1, 32'h0000_4444, 16'h0034);
        tick();
        check("h_issued",     64'(dbus.out_valid), 64'd0);
        check("h_still",      64'(dbus.halted),    64'd1);
        drive(1'b0, 32'h0, 16'h0);
        dbus.resume = 1'b1;
        tick();
        dbus.resume = 1'b0;
        check("r_halted",     64'(dbus.halted),    64'd0);
        check("r_in_ready",   64'(dbus.in_ready),  64'd1);
        check("r_no_intake",  64'(dbus.out_valid), 64'd0);

        // Branch decode
        drive(1'b1, 32'hC460_0000, 16'h0038);
        tick();
        check("b1_branch",    64'(dbus.branch),    64'd1);
        check("b1_br_cond",   64'(dbus.br_cond),   64'h3);
        check("b1_to_pc",     64'(dbus.to_pc),     64'd0);
        drive(1'b1, 32'hC000_0000, 16'h003C);
        tick();
        check("b2_branch",    64'(dbus.branch),    64'd1);
        check("b2_br_cond",   64'(dbus.br_cond),   64'hE);
        check("b2_to_pc",     64'(dbus.to_pc),     64'd1);
        check("b2_halted",    64'(dbus.halted),    64'd0);
        drive(1'b0, 32'h0, 16'h0);
        tick();

        // Flush with main and skid full; intake blocked while flush is high
        dbus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_5555, 16'h0040);
        tick();
        drive(1'b1, 32'h0000_6666, 16'h0044);
        tick();
        check("f_full_pc",    64'(dbus.out_pc),    64'h40);
        drive(1'b1, 32'h0000_7777, 16'h0048);
        dbus.flush = 1'b1;
        #1;
        check("f_rdy_a",      64'(dbus.in_ready),  64'd0);
        tick();
        check("f_valid_a",    64'(dbus.out_valid), 64'd0);
        check("f_halted",     64'(dbus.halted),    64'd0);
        check("f_rdy_b",      64'(dbus.in_ready),  64'd0);
        tick();
        dbus.flush = 1'b0;
        drive(1'b0, 32'h0, 16'h0);
        dbus.out_ready = 1'b1;
        check("f_valid_b",    64'(dbus.out_valid), 64'd0);
        tick();
        check("f_valid_c",    64'(dbus.out_valid), 64'd0);

        // Flush and resume together while halted
        dbus.out_ready = 1'b0;
        drive(1'b1, 32'hD000_0000, 16'h0060);
        tick();
        check("fr_halted",    64'(dbus.halted),    64'd1);
        check("fr_valid",     64'(dbus.out_valid), 64'd1);
        drive(1'b0, 32'h0, 16'h0);
        dbus.flush  = 1'b1;
        dbus.resume = 1'b1;
        tick();
        dbus.flush  = 1'b0;
        dbus.resume = 1'b0;
        check("fr_valid_0",   64'(dbus.out_valid), 64'd0);
        check("fr_halted_0",  64'(dbus.halted),    64'd0);
        #1;
        check("fr_in_ready",  64'(dbus.in_ready),  64'd1);

        // Asynchronous reset between edges while halted with a held bundle
        drive(1'b1, 32'hD000_0000, 16'h0070);
        tick();
        drive(1'b0, 32'h0, 16'h0);
        check("ar_pre_halt",  64'(dbus.halted),    64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid",     64'(dbus.out_valid), 64'd0);
        check("ar_halted",    64'(dbus.halted),    64'd0);
        check("ar_is_halt",   64'(dbus.is_halt),   64'd0);
        check("ar_out_pc",    64'(dbus.out_pc),    64'd0);
        #7;
        rst_n = 1'b1;
        #1;
        check("ar_in_ready",  64'(dbus.in_ready),  64'd1);
        tick();
        check("ar_idle",      64'(dbus.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
